// File: rtl/tis_pkg.sv
// tis_pkg
// Shared definitions for the TIS node grid stack memory:
//   WORD_W          native TIS word width (two's complement)
//   TIS_MAX/TIS_MIN legal TIS value range, used when saturation is built in
//   tis_word_t      signed TIS word
//   tis_dir_e       neighbour direction <-> port index mapping
//   stack_state_e   stack node control states
package tis_pkg;

  localparam int WORD_W  = 11;
  localparam int TIS_MAX = 999;
  localparam int TIS_MIN = -999;

  typedef logic signed [WORD_W-1:0] tis_word_t;

  typedef enum logic [1:0] {
    DIR_LEFT,
    DIR_RIGHT,
    DIR_UP,
    DIR_DOWN
  } tis_dir_e;

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    OFFER
  } stack_state_e;

endpackage

// File: rtl/tis_rr_arbiter.sv
// tis_rr_arbiter
// Combinational round-robin arbiter. The search for a requester begins at
// index ptr and wraps around; the first active request found wins.
// The owner of ptr advances it past the winner after each grant.
// Ports:
//   req    in   N    request vector
//   ptr    in   PW   index where the search starts
//   grant  out  N    one-hot grant (all zero when nothing requests)
module tis_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tis_stack_node.sv
// tis_stack_node
// LIFO stack memory node for the TIS grid. Any of NPORTS neighbours may push
// a word; a neighbour stalled reading this direction is offered the top word.
// Push and pop are each arbitrated round-robin; a pending pop beats a push.
// Ports:
//   clk       in   1                system clock
//   rst       in   1                synchronous active-high reset
//   wr_valid  in   NPORTS           neighbour holds a word for this node
//   wr_data   in   NPORTS*WIDTH     port i word at [i*WIDTH +: WIDTH]
//   wr_ack    out  NPORTS           one-cycle pulse: word taken
//   rd_req    in   NPORTS           neighbour wants a word
//   rd_valid  out  NPORTS           one-hot offer of the top word
//   rd_data   out  WIDTH            top-of-stack while offering, else 0
//   rd_ack    in   NPORTS           neighbour consumed the offered word
//   count     out  $clog2(DEPTH+1)  entries held
//   full      out  1                count == DEPTH
//   empty     out  1                count == 0
// Build option: define STACK_SAT_EN to clamp pushed words to TIS_MIN..TIS_MAX.
module tis_stack_node
  import tis_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = 15,
  parameter int NPORTS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          wr_valid,
  input  logic [NPORTS*WIDTH-1:0]    wr_data,
  output logic [NPORTS-1:0]          wr_ack,
  input  logic [NPORTS-1:0]          rd_req,
  output logic [NPORTS-1:0]          rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  input  logic [NPORTS-1:0]          rd_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NPORTS);

  stack_state_e state, state_n;

  logic [PW-1:0]           push_ptr, pop_ptr;
  logic [PW-1:0]           push_idx, pop_idx;
  logic [NPORTS-1:0]       push_grant, pop_grant;
  logic                    push_go, pop_go, pop_done;
  logic [CW-1:0]           top_idx;
  logic signed [WIDTH-1:0] wr_word [NPORTS];
  logic signed [WIDTH-1:0] stack_mem [DEPTH];
  logic signed [WIDTH-1:0] store_word;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(NPORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

`ifdef STACK_SAT_EN
  function automatic logic signed [WIDTH-1:0] clamp_word(input logic signed [WIDTH-1:0] w);
    if (int'(w) > TIS_MAX) return WIDTH'(TIS_MAX);
    if (int'(w) < TIS_MIN) return WIDTH'(TIS_MIN);
    return w;
  endfunction
`endif

  tis_rr_arbiter #(.N(NPORTS), .PW(PW)) u_push_arb (
    .req   (wr_valid),
    .ptr   (push_ptr),
    .grant (push_grant)
  );

  tis_rr_arbiter #(.N(NPORTS), .PW(PW)) u_pop_arb (
    .req   (rd_req),
    .ptr   (pop_ptr),
    .grant (pop_grant)
  );

  // Unpack the flat word bus and turn the one-hot grants into indices.
  always_comb begin
    push_idx = '0;
    pop_idx  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      wr_word[i] = wr_data[i*WIDTH +: WIDTH];
      if (push_grant[i]) push_idx = PW'(i);
      if (pop_grant[i])  pop_idx  = PW'(i);
    end
  end

`ifdef STACK_SAT_EN
  assign store_word = clamp_word(wr_word[push_idx]);
`else
  assign store_word = wr_word[push_idx];
`endif

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = count - 1'b1;
  assign rd_data = (state == OFFER) ? stack_mem[top_idx] : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic. Only IDLE starts an operation, so a push and a pop can
  // never overlap, and a waiting reader is always served before a writer.
  // rd_valid carries only the granted bit, so masking rd_ack with it ignores
  // acks from ports that were not offered the word.
  always_comb begin
    state_n  = state;
    push_go  = 1'b0;
    pop_go   = 1'b0;
    pop_done = 1'b0;
    unique case (state)
      IDLE: begin
        if ((|rd_req) && !empty) begin
          pop_go  = 1'b1;
          state_n = OFFER;
        end else if ((|wr_valid) && !full) begin
          push_go = 1'b1;
          state_n = PUSH;
        end
      end
      PUSH: state_n = IDLE;
      OFFER: begin
        if (|(rd_ack & rd_valid)) begin
          pop_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs, occupancy and arbiter pointers. wr_ack is a single
  // pulse because the following PUSH cycle never re-grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ack   <= '0;
      rd_valid <= '0;
      push_ptr <= '0;
      pop_ptr  <= '0;
    end else begin
      wr_ack <= push_go ? push_grant : '0;
      if (push_go) begin
        count    <= count + 1'b1;
        push_ptr <= next_ptr(push_idx);
      end
      if (pop_go) begin
        rd_valid <= pop_grant;
        pop_ptr  <= next_ptr(pop_idx);
      end else if (pop_done) begin
        rd_valid <= '0;
        count    <= count - 1'b1;
      end
    end
  end

  // Storage is not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_go) stack_mem[count] <= store_word;
  end

endmodule

// File: tb/tb_tis_stack_node.sv
// tb_tis_stack_node
// Self-checking bench for tis_stack_node. Stimulus tasks queue the expected
// wr_ack grants and popped words; an independent monitor compares them
// against the DUT whenever wr_ack pulses or a new rd_valid offer appears.
// Honours STACK_SAT_EN to pick the expected saturated/unsaturated values.
module tb_tis_stack_node;
  import tis_pkg::*;

  localparam int W  = 11;
  localparam int D  = 15;
  localparam int NP = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        wr_valid;
  logic [NP*W-1:0]      wr_data;
  logic [NP-1:0]        wr_ack;
  logic [NP-1:0]        rd_req;
  logic [NP-1:0]        rd_valid;
  logic signed [W-1:0]  rd_data;
  logic [NP-1:0]        rd_ack;
  logic [3:0]           count;
  logic                 full;
  logic                 empty;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [NP-1:0] ack_q[$];
  int            rd_port_q[$];
  int            rd_data_q[$];
  logic          rv_prev = 1'b0;
  logic [NP-1:0] exp_ack;
  int            exp_port;
  int            exp_data;

  tis_stack_node #(.WIDTH(W), .DEPTH(D), .NPORTS(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ack   (rd_ack),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every wr_ack pulse and every new offer.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_ack != '0) begin
        if (ack_q.size() == 0) checkOutput("unexpected wr_ack", int'(wr_ack), 0);
        else begin
          exp_ack = ack_q.pop_front();
          checkOutput("wr_ack port", int'(wr_ack), int'(exp_ack));
        end
      end
      if (rd_valid != '0 && !rv_prev) begin
        if (rd_port_q.size() == 0) checkOutput("unexpected rd_valid", int'(rd_valid), 0);
        else begin
          exp_port = rd_port_q.pop_front();
          exp_data = rd_data_q.pop_front();
          checkOutput("rd_valid port", int'(rd_valid), 1 << exp_port);
          checkOutput("rd_data", int'(rd_data), exp_data);
        end
      end
    end
    rv_prev <= |rd_valid;
  end

  // Push (is_pop=0) or pop (is_pop=1) one word through a full handshake.
  task automatic applyStimulus(input bit is_pop, input int port, input int value);
    bit got = 1'b0;
    if (!is_pop) begin
      ack_q.push_back(NP'(1 << port));
      wr_data[port*W +: W] = W'(value);
      wr_valid[port] = 1'b1;
      for (int c = 0; c < 60 && !got; c++) begin
        @(posedge clk); #1;
        if (wr_ack[port]) got = 1'b1;
      end
      wr_valid[port] = 1'b0;
      checkOutput("push handshake", int'(got), 1);
    end else begin
      rd_port_q.push_back(port);
      rd_data_q.push_back(value);
      rd_req[port] = 1'b1;
      for (int c = 0; c < 60 && !got; c++) begin
        @(posedge clk); #1;
        if (rd_valid[port]) got = 1'b1;
      end
      rd_req[port] = 1'b0;
      if (got) begin
        rd_ack[port] = 1'b1;
        @(posedge clk); #1;
        rd_ack[port] = 1'b0;
      end
      checkOutput("pop handshake", int'(got), 1);
    end
  endtask

  task automatic doReset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit got, early;
    int n;
    rst = 1'b1; wr_valid = '0; wr_data = '0; rd_req = '0; rd_ack = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset empty", int'(empty), 1);
    checkOutput("reset full", int'(full), 0);
    checkOutput("reset wr_ack", int'(wr_ack), 0);
    checkOutput("reset rd_valid", int'(rd_valid), 0);
    checkOutput("reset rd_data", int'(rd_data), 0);

    // Reset held two cycles while a word is on offer.
    applyStimulus(0, DIR_LEFT, 77);
    rd_port_q.push_back(DIR_RIGHT);
    rd_data_q.push_back(77);
    rd_req[DIR_RIGHT] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (rd_valid[DIR_RIGHT]) got = 1'b1;
    end
    checkOutput("offer before reset", int'(got), 1);
    rd_req = '0;
    doReset(2);
    checkOutput("mid-offer reset rd_valid", int'(rd_valid), 0);
    checkOutput("mid-offer reset count", int'(count), 0);
    checkOutput("mid-offer reset empty", int'(empty), 1);

    // LIFO order.
    applyStimulus(0, DIR_LEFT, 5);
    applyStimulus(0, DIR_LEFT, 7);
    applyStimulus(0, DIR_LEFT, -3);
    checkOutput("lifo count 3", int'(count), 3);
    applyStimulus(1, DIR_RIGHT, -3);
    checkOutput("lifo count 2", int'(count), 2);
    applyStimulus(1, DIR_RIGHT, 7);
    checkOutput("lifo count 1", int'(count), 1);
    applyStimulus(1, DIR_RIGHT, 5);
    checkOutput("lifo count 0", int'(count), 0);
    checkOutput("lifo empty", int'(empty), 1);

    // Fill to DEPTH, then a stalled push released by one pop.
    for (int i = 0; i < D; i++) applyStimulus(0, DIR_LEFT, 10 + i);
    checkOutput("fill full", int'(full), 1);
    checkOutput("fill count", int'(count), 15);
    ack_q.push_back(NP'(1 << DIR_UP));
    wr_data[DIR_UP*W +: W] = W'(100);
    wr_valid[DIR_UP] = 1'b1;
    early = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wr_ack[DIR_UP]) early = 1'b1;
    end
    checkOutput("no ack while full", int'(early), 0);
    applyStimulus(1, DIR_DOWN, 24);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (wr_ack[DIR_UP]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    wr_valid[DIR_UP] = 1'b0;
    checkOutput("stalled push accepted", int'(got), 1);
    checkOutput("refill count", int'(count), 15);
    applyStimulus(1, DIR_RIGHT, 100);
    for (int i = D - 2; i >= 0; i--) applyStimulus(1, DIR_RIGHT, 10 + i);
    checkOutput("drain empty", int'(empty), 1);

    // Round-robin push fairness from a freshly reset pointer.
    doReset(1);
    ack_q.push_back(4'b0001);
    ack_q.push_back(4'b0010);
    ack_q.push_back(4'b0100);
    ack_q.push_back(4'b1000);
    ack_q.push_back(4'b0001);
    for (int p = 0; p < NP; p++) wr_data[p*W +: W] = W'(p + 1);
    wr_valid = '1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(posedge clk); #1;
      if (wr_ack != '0) n++;
    end
    wr_valid = '0;
    checkOutput("rr grant count", n, 5);
    checkOutput("rr stack count", int'(count), 5);
    doReset(1);

    // Simultaneous read request and write: pop first.
    applyStimulus(0, DIR_LEFT, 42);
    rd_port_q.push_back(DIR_RIGHT);
    rd_data_q.push_back(42);
    ack_q.push_back(NP'(1 << DIR_UP));
    wr_data[DIR_UP*W +: W] = W'(9);
    rd_req[DIR_RIGHT] = 1'b1;
    wr_valid[DIR_UP] = 1'b1;
    got = 1'b0; early = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (wr_ack[DIR_UP]) early = 1'b1;
      if (rd_valid[DIR_RIGHT]) got = 1'b1;
    end
    rd_req = '0;
    checkOutput("pop offered", int'(got), 1);
    checkOutput("pop before push", int'(early), 0);
    rd_ack[DIR_RIGHT] = 1'b1;
    @(posedge clk); #1;
    rd_ack = '0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (wr_ack[DIR_UP]) got = 1'b1;
    end
    wr_valid = '0;
    checkOutput("push after pop", int'(got), 1);
    checkOutput("pop/push count", int'(count), 1);
    applyStimulus(1, DIR_LEFT, 9);

    // Out-of-range words.
    applyStimulus(0, DIR_LEFT, 1023);
    applyStimulus(0, DIR_LEFT, -1024);
`ifdef STACK_SAT_EN
    applyStimulus(1, DIR_LEFT, -999);
    applyStimulus(1, DIR_LEFT, 999);
`else
    applyStimulus(1, DIR_LEFT, -1024);
    applyStimulus(1, DIR_LEFT, 1023);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("ack scoreboard drained", ack_q.size(), 0);
    checkOutput("pop scoreboard drained", rd_port_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
